// File: rtl/sw_pkg.sv
// Shared types and constants for the lap stopwatch: BCD digit width,
// per-digit roll-over limits, FSM state type and the packed time record.
package sw_pkg;

    localparam int BCD_W      = 4;

    // Highest value each digit reaches before it rolls over to zero.
    localparam int CS_LIM     = 9;  // both centisecond digits
    localparam int SEC_LO_LIM = 9;
    localparam int SEC_HI_LIM = 5;
    localparam int MIN_LO_LIM = 9;
    localparam int MIN_HI_LIM = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } sw_state_e;

    // MM:SS.cc as six BCD digits, most significant first.
    typedef struct packed {
        logic [BCD_W-1:0] m1;
        logic [BCD_W-1:0] m0;
        logic [BCD_W-1:0] s1;
        logic [BCD_W-1:0] s0;
        logic [BCD_W-1:0] c1;
        logic [BCD_W-1:0] c0;
    } time_bcd_t;

    // True when the time shows 59:59.99, the last value before roll-over.
    function automatic logic is_time_max(input time_bcd_t t);
        return (t.m1 == BCD_W'(MIN_HI_LIM)) && (t.m0 == BCD_W'(MIN_LO_LIM)) &&
               (t.s1 == BCD_W'(SEC_HI_LIM)) && (t.s0 == BCD_W'(SEC_LO_LIM)) &&
               (t.c1 == BCD_W'(CS_LIM))     && (t.c0 == BCD_W'(CS_LIM));
    endfunction

endpackage

// File: rtl/bcd_digit_ctr.sv
// One BCD digit of the stopwatch. Counts 0..LIMIT when enabled and raises a
// combinational carry on the enabled step that wraps it back to zero, so a
// chain of these ripples the whole time value in a single cycle.
module bcd_digit_ctr
    import sw_pkg::*;
#(
    parameter int LIMIT = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    output logic [BCD_W-1:0] q,
    output logic             carry
);

    localparam logic [BCD_W-1:0] LIM = BCD_W'(LIMIT);

    logic [BCD_W-1:0] q_q;
    logic [BCD_W-1:0] q_d;

    assign carry = en && (q_q == LIM);
    assign q     = q_q;

    // Next digit value: clear beats count, count wraps at LIMIT.
    always_comb begin
        // NOTE: default assignment first so no path leaves q_d unassigned (no latch).
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (en) begin
            q_d = carry ? '0 : q_q + BCD_W'(1);
        end
    end

    // Digit register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignment so every flop samples pre-edge values.
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

endmodule

// File: rtl/lap_stopwatch.sv
// MM:SS.cc BCD stopwatch with run/pause/idle control, clear, and a
// first-word-fall-through lap FIFO for the display mux.
// Optional build macro: LAP_STOPWATCH_SATURATE_EN -- when defined the time
// holds at 59:59.99 instead of wrapping, and the overflow flag lap_ovf is set.
module lap_stopwatch
    import sw_pkg::*;
#(
    parameter  int LAP_DEPTH   = 8,
    parameter  int SYNC_STAGES = 2,
    localparam int LAP_AW      = $clog2(LAP_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_100hz,
    input  logic              btn_start_stop,
    input  logic              btn_lap,
    input  logic              btn_clear,
    input  logic              lap_rd,
    output logic [23:0]       time_bcd,
    output logic [23:0]       lap_bcd,
    output logic [LAP_AW:0]   lap_count,
    output logic              lap_empty,
    output logic              lap_full,
    output logic              lap_ovf,
    output logic              running,
    output logic              wrap
);

    localparam int B_SS  = 0;
    localparam int B_LAP = 1;
    localparam int B_CLR = 2;

    // ---------------- button synchronisers and edge detect ----------------
    logic [2:0]                  btn_raw;
    logic [2:0][SYNC_STAGES-1:0] sync_q;
    logic [2:0]                  prev_q;
    logic [2:0]                  btn_lvl;
    logic [2:0]                  btn_pulse;

    assign btn_raw = {btn_clear, btn_lap, btn_start_stop};

    // Synchronised level of each button is the last stage of its chain.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            btn_lvl[i] = sync_q[i][SYNC_STAGES-1];
        end
    end

    assign btn_pulse = btn_lvl & ~prev_q;

    // Shift raw buttons through the synchroniser and remember the last level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], btn_raw[i]};
            end
            prev_q <= btn_lvl;
        end
    end

    // ---------------- control FSM ----------------
    sw_state_e state_q;
    logic      running_q;

    // Start/stop toggles RUN; clear from PAUSE returns to IDLE and wins over start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            running_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (btn_pulse[B_SS]) begin
                        state_q   <= RUN;
                        running_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (btn_pulse[B_SS]) begin
                        state_q   <= PAUSE;
                        running_q <= 1'b0;
                    end
                end
                PAUSE: begin
                    if (btn_pulse[B_CLR]) begin
                        state_q   <= IDLE;
                        running_q <= 1'b0;
                    end else if (btn_pulse[B_SS]) begin
                        state_q   <= RUN;
                        running_q <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

    logic clear_do;
    logic run_tick;
    logic cnt_en;
    logic sat_hit;

    assign clear_do = btn_pulse[B_CLR] && (state_q == PAUSE);
    assign run_tick = tick_100hz && (state_q == RUN);

    // ---------------- time counter ----------------
    time_bcd_t        time_q;
    logic [BCD_W-1:0] d_c0, d_c1, d_s0, d_s1, d_m0, d_m1;
    logic             cy_c0, cy_c1, cy_s0, cy_s1, cy_m0, cy_m1;
    logic             wrap_q;

    assign time_q = {d_m1, d_m0, d_s1, d_s0, d_c1, d_c0};

`ifdef LAP_STOPWATCH_SATURATE_EN
    assign cnt_en  = run_tick && !is_time_max(time_q);
    assign sat_hit = run_tick &&  is_time_max(time_q);
`else
    assign cnt_en  = run_tick;
    assign sat_hit = 1'b0;
`endif

    bcd_digit_ctr #(.LIMIT(CS_LIM)) u_c0 (
        .clk(clk), .rst(rst), .en(cnt_en), .clr(clear_do), .q(d_c0), .carry(cy_c0));
    bcd_digit_ctr #(.LIMIT(CS_LIM)) u_c1 (
        .clk(clk), .rst(rst), .en(cy_c0),  .clr(clear_do), .q(d_c1), .carry(cy_c1));
    bcd_digit_ctr #(.LIMIT(SEC_LO_LIM)) u_s0 (
        .clk(clk), .rst(rst), .en(cy_c1),  .clr(clear_do), .q(d_s0), .carry(cy_s0));
    bcd_digit_ctr #(.LIMIT(SEC_HI_LIM)) u_s1 (
        .clk(clk), .rst(rst), .en(cy_s0),  .clr(clear_do), .q(d_s1), .carry(cy_s1));
    bcd_digit_ctr #(.LIMIT(MIN_LO_LIM)) u_m0 (
        .clk(clk), .rst(rst), .en(cy_s1),  .clr(clear_do), .q(d_m0), .carry(cy_m0));
    bcd_digit_ctr #(.LIMIT(MIN_HI_LIM)) u_m1 (
        .clk(clk), .rst(rst), .en(cy_m0),  .clr(clear_do), .q(d_m1), .carry(cy_m1));

    // Carry out of the top digit marks the 59:59.99 -> 00:00.00 roll-over.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= cy_m1;
        end
    end

    // ---------------- lap FIFO ----------------
    time_bcd_t          lap_mem [LAP_DEPTH];
    logic [LAP_AW-1:0]  wr_ptr_q;
    logic [LAP_AW-1:0]  rd_ptr_q;
    logic [LAP_AW:0]    cnt_q;
    logic               ovf_q;
    logic               fifo_full;
    logic               fifo_empty;
    logic               lap_req;
    logic               do_push;
    logic               do_pop;
    logic               drop;

    assign fifo_full  = (cnt_q == (LAP_AW+1)'(LAP_DEPTH));
    assign fifo_empty = (cnt_q == '0);
    assign lap_req    = btn_pulse[B_LAP] && (state_q == RUN);
    assign do_pop     = lap_rd && !fifo_empty;
    // A pop on the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push    = lap_req && (!fifo_full || do_pop);
    assign drop       = lap_req && fifo_full && !do_pop;

    // Lap storage, written with the pre-increment time.
    always_ff @(posedge clk) begin
        // NOTE: storage has no reset; the count gates every read, so stale data is never shown.
        if (do_push) begin
            lap_mem[wr_ptr_q] <= time_q;
        end
    end

    // Pointers, occupancy and the sticky overflow flag; clear empties everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else if (clear_do) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + LAP_AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + LAP_AW'(1);
            end
            if (do_push && !do_pop) begin
                cnt_q <= cnt_q + (LAP_AW+1)'(1);
            end else if (do_pop && !do_push) begin
                cnt_q <= cnt_q - (LAP_AW+1)'(1);
            end
            if (drop || sat_hit) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // ---------------- outputs ----------------
    assign time_bcd  = time_q;
    assign lap_bcd   = fifo_empty ? 24'h0 : lap_mem[rd_ptr_q];
    assign lap_count = cnt_q;
    assign lap_empty = fifo_empty;
    assign lap_full  = fifo_full;
    assign lap_ovf   = ovf_q;
    assign running   = running_q;
    assign wrap      = wrap_q;

endmodule

// File: tb/tb_lap_stopwatch.sv
// Bench for lap_stopwatch: directed vector table, hand-written corner cases,
// then random stimulus, all compared against a centisecond-integer reference
// model. Honours LAP_STOPWATCH_SATURATE_EN for the overflow behaviour.
module tb_lap_stopwatch;

    localparam int LAP_DEPTH   = 8;
    localparam int LAP_AW      = $clog2(LAP_DEPTH);
    localparam int SYNC_STAGES = 2;
    localparam int MAX_CS      = 359999;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              tick_100hz = 1'b0;
    logic              btn_start_stop = 1'b0;
    logic              btn_lap = 1'b0;
    logic              btn_clear = 1'b0;
    logic              lap_rd = 1'b0;
    logic [23:0]       time_bcd;
    logic [23:0]       lap_bcd;
    logic [LAP_AW:0]   lap_count;
    logic              lap_empty, lap_full, lap_ovf, running, wrap;

    int n_pass  = 0;
    int n_total = 0;

    lap_stopwatch #(.LAP_DEPTH(LAP_DEPTH), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk(clk), .rst(rst), .tick_100hz(tick_100hz),
        .btn_start_stop(btn_start_stop), .btn_lap(btn_lap), .btn_clear(btn_clear),
        .lap_rd(lap_rd), .time_bcd(time_bcd), .lap_bcd(lap_bcd),
        .lap_count(lap_count), .lap_empty(lap_empty), .lap_full(lap_full),
        .lap_ovf(lap_ovf), .running(running), .wrap(wrap));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [23:0] to_bcd(input int cs);
        int m, s, c;
        m = cs / 6000;
        s = (cs / 100) % 60;
        c = cs % 100;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
    endfunction

    // ---------------- reference model ----------------
    int          m_cs;
    bit          m_run, m_paused, m_ovf, m_wrap;
    logic [23:0] m_q[$];
    bit          h_ss [SYNC_STAGES+2];
    bit          h_lap[SYNC_STAGES+2];
    bit          h_clr[SYNC_STAGES+2];

    task automatic model_reset();
        m_cs = 0; m_run = 0; m_paused = 0; m_ovf = 0; m_wrap = 0;
        m_q.delete();
        for (int i = 0; i < SYNC_STAGES + 2; i++) begin
            h_ss[i] = 0; h_lap[i] = 0; h_clr[i] = 0;
        end
    endtask

    // A press is acted on SYNC_STAGES+1 edges after the edge that first sees it.
    task automatic model_step();
        bit ss_ev, lap_ev, clr_ev;
        logic [23:0] cur;
        for (int i = SYNC_STAGES + 1; i > 0; i--) begin
            h_ss[i] = h_ss[i-1]; h_lap[i] = h_lap[i-1]; h_clr[i] = h_clr[i-1];
        end
        h_ss[0] = btn_start_stop; h_lap[0] = btn_lap; h_clr[0] = btn_clear;
        ss_ev  = h_ss[SYNC_STAGES]  & ~h_ss[SYNC_STAGES+1];
        lap_ev = h_lap[SYNC_STAGES] & ~h_lap[SYNC_STAGES+1];
        clr_ev = h_clr[SYNC_STAGES] & ~h_clr[SYNC_STAGES+1];
        cur    = to_bcd(m_cs);
        m_wrap = 0;
        if (clr_ev && m_paused) begin
            m_paused = 0; m_run = 0; m_cs = 0; m_ovf = 0;
            m_q.delete();
        end else begin
            if (lap_rd && m_q.size() > 0) void'(m_q.pop_front());
            if (lap_ev && m_run) begin
                if (m_q.size() < LAP_DEPTH) m_q.push_back(cur);
                else m_ovf = 1;
            end
            if (m_run && tick_100hz) begin
                if (m_cs == MAX_CS) begin
`ifdef LAP_STOPWATCH_SATURATE_EN
                    m_ovf = 1;
`else
                    m_cs = 0; m_wrap = 1;
`endif
                end else begin
                    m_cs++;
                end
            end
            if (ss_ev) begin
                if (m_run) begin m_run = 0; m_paused = 1; end
                else       begin m_run = 1; m_paused = 0; end
            end
        end
    endtask

    always @(posedge clk) begin
        if (!rst) begin
            model_step();
            #1;
            check("mdl_time",  time_bcd,  to_bcd(m_cs));
            check("mdl_lap",   lap_bcd,   (m_q.size() > 0) ? m_q[0] : 24'h0);
            check("mdl_count", lap_count, m_q.size());
            check("mdl_empty", lap_empty, m_q.size() == 0);
            check("mdl_full",  lap_full,  m_q.size() == LAP_DEPTH);
            check("mdl_ovf",   lap_ovf,   m_ovf);
            check("mdl_run",   running,   m_run);
            check("mdl_wrap",  wrap,      m_wrap);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int n, input bit tk);
        repeat (n) begin
            @(negedge clk);
            tick_100hz = tk;
        end
        @(negedge clk);
        tick_100hz = 0;
        lap_rd = 0;
    endtask

    task automatic press(input bit ss, input bit lp, input bit cl);
        @(negedge clk);
        tick_100hz = 0;
        btn_start_stop = ss; btn_lap = lp; btn_clear = cl;
        repeat (2) @(negedge clk);
        btn_start_stop = 0; btn_lap = 0; btn_clear = 0;
        repeat (SYNC_STAGES + 1) @(negedge clk);
    endtask

    // Lap press with lap_rd high on exactly the cycle the lap is acted on.
    task automatic lap_with_rd();
        @(negedge clk);
        tick_100hz = 0;
        btn_lap = 1;
        repeat (SYNC_STAGES) @(negedge clk);
        lap_rd = 1;
        @(negedge clk);
        lap_rd = 0;
        btn_lap = 0;
        repeat (SYNC_STAGES + 1) @(negedge clk);
    endtask

    task automatic pop();
        @(negedge clk);
        lap_rd = 1;
        @(negedge clk);
        lap_rd = 0;
    endtask

    // Load 59:59.99 directly; held across one edge so the flops keep it.
    task automatic preload_max();
        @(negedge clk);
        force dut.u_c0.q_q = 4'd9;
        force dut.u_c1.q_q = 4'd9;
        force dut.u_s0.q_q = 4'd9;
        force dut.u_s1.q_q = 4'd5;
        force dut.u_m0.q_q = 4'd9;
        force dut.u_m1.q_q = 4'd5;
        m_cs = MAX_CS;
        @(posedge clk);
        @(negedge clk);
        release dut.u_c0.q_q;
        release dut.u_c1.q_q;
        release dut.u_s0.q_q;
        release dut.u_s1.q_q;
        release dut.u_m0.q_q;
        release dut.u_m1.q_q;
    endtask

    typedef struct {
        bit          press_ss;
        bit          press_clr;
        int          ticks;
        logic [23:0] exp_time;
        bit          exp_running;
    } vec_t;

    vec_t vecs[10];
    int   exp_cs[$];

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1,    24'h000001, 1'b1};
        vecs[1] = '{1'b0, 1'b0, 8,    24'h000009, 1'b1};
        vecs[2] = '{1'b0, 1'b0, 1,    24'h000010, 1'b1};
        vecs[3] = '{1'b0, 1'b0, 89,   24'h000099, 1'b1};
        vecs[4] = '{1'b0, 1'b0, 1,    24'h000100, 1'b1};
        vecs[5] = '{1'b0, 1'b0, 5900, 24'h010000, 1'b1};
        vecs[6] = '{1'b1, 1'b0, 50,   24'h010000, 1'b0};
        vecs[7] = '{1'b0, 1'b1, 0,    24'h000000, 1'b0};
        vecs[8] = '{1'b1, 1'b0, 123,  24'h000123, 1'b1};
        vecs[9] = '{1'b0, 1'b1, 1,    24'h000124, 1'b1};

        model_reset();
        repeat (3) @(negedge clk);
        check("rst_time",  time_bcd,  0);
        check("rst_lap",   lap_bcd,   0);
        check("rst_empty", lap_empty, 1);
        check("rst_run",   running,   0);
        rst = 0;

        // Count to 00:12.34, then reset asynchronously between edges.
        press(1, 0, 0);
        idle(1234, 1);
        check("pre_rst_time", time_bcd, 24'h001234);
        @(negedge clk);
        #2 rst = 1;
        model_reset();
        #1;
        check("arst_time",  time_bcd,  0);
        check("arst_count", lap_count, 0);
        check("arst_empty", lap_empty, 1);
        check("arst_full",  lap_full,  0);
        check("arst_ovf",   lap_ovf,   0);
        check("arst_run",   running,   0);
        check("arst_wrap",  wrap,      0);
        @(negedge clk);
        rst = 0;

        // Vector table: presses then ticks, compared with hand-derived times.
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].press_ss)  press(1, 0, 0);
            if (vecs[i].press_clr) press(0, 0, 1);
            idle(vecs[i].ticks, 1);
            check($sformatf("vec%0d_time", i), time_bcd, vecs[i].exp_time);
            check($sformatf("vec%0d_run", i),  running,  vecs[i].exp_running);
        end

        // Top-of-range behaviour.
        press(1, 0, 0);
        preload_max();
        check("max_time", time_bcd, 24'h595999);
        press(1, 0, 0);
        @(negedge clk);
        tick_100hz = 1;
        @(negedge clk);
        tick_100hz = 0;
`ifdef LAP_STOPWATCH_SATURATE_EN
        check("sat_time", time_bcd, 24'h595999);
        check("sat_wrap", wrap, 0);
        check("sat_ovf",  lap_ovf, 1);
        check("sat_run",  running, 1);
`else
        check("wrap_time", time_bcd, 0);
        check("wrap_hi",   wrap, 1);
        @(negedge clk);
        check("wrap_lo",   wrap, 0);
        check("wrap_run",  running, 1);
`endif
        press(1, 0, 0);
        press(0, 0, 1);

        // Two laps, then read-out.
        press(1, 0, 0);
        idle(123, 1);
        press(0, 1, 0);
        idle(127, 1);
        press(0, 1, 0);
        check("lap2_count", lap_count, 2);
        check("lap2_head",  lap_bcd, 24'h000123);
        pop();
        check("pop1_head",  lap_bcd, 24'h000250);
        check("pop1_count", lap_count, 1);
        pop();
        check("pop2_empty", lap_empty, 1);
        check("pop2_head",  lap_bcd, 0);
        pop();
        check("pop_empty_count", lap_count, 0);

        // Fill, simultaneous push+pop while full, then overflow.
        for (int i = 0; i < LAP_DEPTH; i++) begin
            idle(7, 1);
            press(0, 1, 0);
            exp_cs.push_back(250 + 7 * (i + 1));
        end
        check("fill_full",  lap_full, 1);
        check("fill_count", lap_count, LAP_DEPTH);
        check("fill_ovf",   lap_ovf, 0);
        idle(7, 1);
        lap_with_rd();
        void'(exp_cs.pop_front());
        exp_cs.push_back(250 + 7 * (LAP_DEPTH + 1));
        check("pushpop_count", lap_count, LAP_DEPTH);
        check("pushpop_ovf",   lap_ovf, 0);
        idle(7, 1);
        press(0, 1, 0);
        check("drop_ovf",   lap_ovf, 1);
        check("drop_count", lap_count, LAP_DEPTH);
        press(1, 0, 0);
        for (int i = 0; i < LAP_DEPTH; i++) begin
            check($sformatf("order%0d", i), lap_bcd, to_bcd(exp_cs[i]));
            pop();
        end
        check("drain_empty", lap_empty, 1);
        check("drain_ovf",   lap_ovf, 1);

        // Clear from PAUSE, then start+clear together while paused.
        press(0, 0, 1);
        check("clr_time",  time_bcd, 0);
        check("clr_empty", lap_empty, 1);
        check("clr_ovf",   lap_ovf, 0);
        check("clr_run",   running, 0);
        press(1, 0, 0);
        idle(5, 1);
        press(1, 0, 0);
        press(1, 0, 1);
        check("ssclr_run",  running, 0);
        check("ssclr_time", time_bcd, 0);
        press(1, 0, 0);
        check("from_idle_run", running, 1);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            tick_100hz = 1'($urandom_range(0, 1));
            lap_rd     = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) == 0)  btn_start_stop = ~btn_start_stop;
            if ($urandom_range(0, 5) == 0)  btn_lap        = ~btn_lap;
            if ($urandom_range(0, 11) == 0) btn_clear      = ~btn_clear;
        end
        @(negedge clk);
        tick_100hz = 0; lap_rd = 0;
        btn_start_stop = 0; btn_lap = 0; btn_clear = 0;
        repeat (SYNC_STAGES + 3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
